// File: rtl/ro_sweep_ctrl.sv
// Ring-oscillator sweep sequencer: steps the select code, settles, counts tap edges, reports (code,count).
// Optional peak tracking is built when RO_PEAK_TRACK_EN is defined.
module ro_sweep_ctrl #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned QUIET_CYCLES  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [4:0]       cfg_code_first,
  input  logic [4:0]       cfg_code_last,
  input  logic [2:0]       cfg_tap,
  output logic [4:0]       s_out,
  output logic             ro_start,
  input  logic [4:0]       ro_tap,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_code,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf,
  output logic             busy,
  output logic             done
`ifdef RO_PEAK_TRACK_EN
  ,
  output logic [4:0]       peak_code,
  output logic [CNT_W-1:0] peak_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT,
    QUIET,
    DONE
  } state_e;

  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LD   = 32'(GATE_CYCLES - 1);
  localparam logic [31:0] QUIET_LD  = 32'(QUIET_CYCLES - 1);

  state_e           state_q;
  logic [4:0]       code_q;
  logic [4:0]       last_q;
  logic [2:0]       tap_q;
  logic [4:0]       s_out_q;
  logic [31:0]      timer_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             ro_start_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic             tap_sel;
  logic             edge_det;
`ifdef RO_PEAK_TRACK_EN
  logic [4:0]       peak_code_q;
  logic [CNT_W-1:0] peak_count_q;
`endif

  always_comb begin
    tap_sel = 1'b0;
    case (tap_q)
      3'd0:    tap_sel = ro_tap[0];
      3'd1:    tap_sel = ro_tap[1];
      3'd2:    tap_sel = ro_tap[2];
      3'd3:    tap_sel = ro_tap[3];
      3'd4:    tap_sel = ro_tap[4];
      default: tap_sel = 1'b0;
    endcase
  end

  // prev follows sync2 every cycle, so on MEASURE entry it already holds the current level
  assign edge_det = sync2_q & ~prev_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tap_sel;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      code_q      <= '0;
      last_q      <= '0;
      tap_q       <= '0;
      s_out_q     <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      ro_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RO_PEAK_TRACK_EN
      peak_code_q  <= '0;
      peak_count_q <= '0;
`endif
    end else if (cmd_abort) begin
      state_q     <= IDLE;
      s_out_q     <= '0;
      ro_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            last_q     <= cfg_code_last;
            tap_q      <= cfg_tap;
            code_q     <= cfg_code_first;
            s_out_q    <= cfg_code_first;
            ro_start_q <= 1'b1;
            busy_q     <= 1'b1;
            timer_q    <= SETTLE_LD;
            state_q    <= SETTLE;
`ifdef RO_PEAK_TRACK_EN
            peak_code_q  <= '0;
            peak_count_q <= '0;
`endif
          end
        end
        SETTLE: begin
          if (timer_q == '0) begin
            timer_q <= GATE_LD;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= MEASURE;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            if (&cnt_q) ovf_q <= 1'b1;
            else        cnt_q <= cnt_q + 1'b1;
          end
          if (timer_q == '0) begin
            res_valid_q <= 1'b1;
            state_q     <= REPORT;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ro_start_q  <= 1'b0;
`ifdef RO_PEAK_TRACK_EN
            if (cnt_q > peak_count_q) begin
              peak_code_q  <= code_q;
              peak_count_q <= cnt_q;
            end
`endif
            if (code_q == last_q) begin
              s_out_q <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              code_q  <= code_q + 5'd1;
              s_out_q <= code_q + 5'd1;
              timer_q <= QUIET_LD;
              state_q <= QUIET;
            end
          end
        end
        QUIET: begin
          if (timer_q == '0) begin
            ro_start_q <= 1'b1;
            timer_q    <= SETTLE_LD;
            state_q    <= SETTLE;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_out     = s_out_q;
  assign ro_start  = ro_start_q;
  assign res_valid = res_valid_q;
  assign res_code  = code_q;
  assign res_count = cnt_q;
  assign res_ovf   = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef RO_PEAK_TRACK_EN
  assign peak_code  = peak_code_q;
  assign peak_count = peak_count_q;
`endif

endmodule
